mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit storage words.
REQ-002 Parameter WAIT_CYCLES, default 2, legal range 1..15: wait-state cycles before a response.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 req_signed  input  1  load sign-extends when 1 (lb/lh); zero-extends when 0 (lbu/lhu).
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  initiator accepts the response.
REQ-014 resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-015 resp_err  output  1  request was misaligned, out of range or illegal size.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; all req_* fields are captured at that edge and later input changes have no effect.
REQ-018 Acceptance SHALL move IDLE->WAIT and load the wait counter with WAIT_CYCLES.
REQ-019 In WAIT the counter SHALL decrement each edge; the edge where it goes 1->0 SHALL move WAIT->RESP.
REQ-020 With the accepting edge numbered 0, resp_valid SHALL be 1 after edge WAIT_CYCLES and hold, with resp_rdata and resp_err stable, until the resp_valid=1 and resp_ready=1 edge.
REQ-021 That handshake edge SHALL move RESP->IDLE and clear resp_valid, resp_rdata and resp_err to 0.
REQ-022 Back-to-back requests SHALL therefore be separated by at least one IDLE cycle; a req_valid held in WAIT or RESP SHALL be ignored until IDLE.
REQ-023 The memory access SHALL occur on the WAIT->RESP edge; stores become visible to any later accepted load.
REQ-024 Byte order SHALL be big-endian: byte offset 0 occupies word bits [31:24], offset 3 occupies [7:0]; halfword offset 0 occupies [31:16].
REQ-025 Byte and halfword stores SHALL modify only the addressed lanes; the other lanes are preserved.
REQ-026 A load SHALL return the addressed byte or halfword in resp_rdata low bits, extended per req_signed; a word load returns the full word.
REQ-027 The word index SHALL be req_addr[31:2]; an index >= DEPTH_WORDS SHALL be out of range.
REQ-028 A halfword with addr[0]=1, a word with addr[1:0]!=0, req_size=11 or an out-of-range index SHALL set resp_err=1 and resp_rdata=0, leave memory unchanged, and keep the same latency.
REQ-029 Memory contents SHALL NOT be reset; reading a never-written word returns an unspecified value with resp_err=0.

Reset
REQ-030 While rst_n=0: state IDLE, wait counter 0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-031 A reset asserted in WAIT SHALL abort the request; a store not yet at its WAIT->RESP edge SHALL NOT be committed.
REQ-032 A reset asserted in RESP SHALL discard the pending response; a store already committed stays committed.
REQ-033 The first request SHALL be accepted on the first rising edge with rst_n=1 and req_valid=1.

Verification
REQ-034 With WAIT_CYCLES=2: sw 0x11223344 @0x10, then lw @0x10 -> resp_valid after edge 2 of each request; rdata 0x11223344, err 0.
REQ-035 After REQ-034: sb 0xAA @0x11, then lbu @0x11 -> 0x000000AA; lb @0x11 -> 0xFFFFFFAA; lw @0x10 -> 0x11AA3344.
REQ-036 After REQ-035: lh @0x12 -> 0x00003344; sh 0x8001 @0x12, then lh @0x12 -> 0xFFFF8001.
REQ-037 lw @0x13, lh @0x11, lw @(DEPTH_WORDS*4) and size=11 -> err=1, rdata=0, no memory change; follow-up lw @0x10 returns the prior value.
REQ-038 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid/rdata stable and req_ready=0 throughout; req_valid held meanwhile is accepted only after the return to IDLE.
REQ-039 sw 0xDEADBEEF @0x20 with rst_n pulsed low in WAIT, then lw @0x20 after reset -> the old contents, not 0xDEADBEEF; outputs 0 during reset.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory target with a fixed wait-state
// latency, big-endian byte/halfword/word access and error reporting.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake (ready only while IDLE)
//   req_write           1 = store, 0 = load
//   req_size            00 byte, 01 halfword, 10 word, 11 illegal
//   req_signed          sign-extend byte/halfword loads when 1
//   req_addr            byte address (word index = addr[31:2])
//   req_wdata           right-justified store data
//   resp_valid/ready    response handshake
//   resp_rdata          extended load data, 0 for stores and errors
//   resp_err            misaligned, out-of-range or illegal-size request
//   dbg_state           current FSM state (0 IDLE, 1 WAIT, 2 RESP)
//
// Handshake rule: a transfer happens on a rising clk edge where valid and
// ready are both 1; valid, once raised by this block, stays up with stable
// payload until that edge.

module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;

  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        commit;
  logic        err;
  logic [31:0] old_word;
  logic [31:0] load_val;
  logic [31:0] store_word;
  logic [4:0]  sh_b;
  logic [4:0]  sh_h;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign accept    = req_valid && (state_q == S_IDLE);
  // The access happens on the edge where the wait counter runs 1 -> 0.
  assign commit    = (state_q == S_WAIT) && (cnt_q == 4'd1);
  assign req_ready = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign dbg_state = state_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_WAIT;
      S_WAIT:  if (cnt_q == 4'd1) state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Error classification and big-endian lane handling of the captured request.
  // Byte offset o sits at bit 8*(3-o); ~addr[1:0] equals 3-o.
  always_comb begin
    err = 1'b0;
    case (size_q)
      2'b01:   err = addr_q[0];
      2'b10:   err = (addr_q[1:0] != 2'b00);
      2'b11:   err = 1'b1;
      default: err = 1'b0;
    endcase
    if ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS)) err = 1'b1;

    old_word = mem[addr_q[AW+1:2]];
    sh_b     = {~addr_q[1:0], 3'b000};
    sh_h     = {~addr_q[1], 4'b0000};
    byte_v   = 8'(old_word >> sh_b);
    half_v   = 16'(old_word >> sh_h);

    case (size_q)
      2'b00:   load_val = signed_q ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
      2'b01:   load_val = signed_q ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
      default: load_val = old_word;
    endcase

    case (size_q)
      2'b00:   store_word = (old_word & ~(32'h0000_00FF << sh_b)) |
                            ({24'd0, wdata_q[7:0]} << sh_b);
      2'b01:   store_word = (old_word & ~(32'h0000_FFFF << sh_h)) |
                            ({16'd0, wdata_q[15:0]} << sh_h);
      default: store_word = wdata_q;
    endcase
  end

  // Control, capture and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q    <= 4'(WAIT_CYCLES);
        write_q  <= req_write;
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end

      if (commit) begin
        resp_rdata <= (err || write_q) ? 32'd0 : load_val;
        resp_err   <= err;
      end else if ((state_q == S_RESP) && resp_ready) begin
        resp_rdata <= 32'd0;
        resp_err   <= 1'b0;
      end
    end
  end

  // Storage is deliberately not reset. A reset during WAIT forces the state
  // to IDLE, so commit cannot fire for an aborted store.
  always_ff @(posedge clk) begin
    if (commit && write_q && !err) mem[addr_q[AW+1:2]] <= store_word;
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and randomized checks of mem_responder against a
// byte-addressed reference memory model.

module tb_mem_responder;

  localparam int DEPTH = 256;
  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // Reference memory: one entry per byte address, big-endian word layout.
  logic [7:0] ref_b [int];
  logic [31:0] exp_q [$];

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic ref_access(input logic wr, input logic [1:0] sz, input logic sg,
                            input logic [31:0] ad, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er);
    int n;
    logic [31:0] v;
    er = (sz == 2'b11) || (sz == 2'b01 && ad % 2 != 0) ||
         (sz == 2'b10 && ad % 4 != 0) || ((ad / 4) >= DEPTH);
    rd = 32'd0;
    if (er) return;
    n = 1 << sz;
    if (wr) begin
      for (int i = 0; i < n; i++) ref_b[int'(ad) + i] = 8'((wd >> (8 * (n - 1 - i))));
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++)
        v = (v << 8) | {24'd0, ref_b.exists(int'(ad) + i) ? ref_b[int'(ad) + i] : 8'h00};
      if (sg && n == 1 && v >= 32'd128)   v = v - 32'd256;
      if (sg && n == 2 && v >= 32'd32768) v = v - 32'd65536;
      rd = v;
    end
  endtask

  // ---------------- driver ----------------
  // Issues one request, checks latency, response payload, hold stability and
  // the post-handshake clear. With keep_req=1 a request stays asserted during
  // the hold phase so the caller can verify it is not taken early.
  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] ad, input logic [31:0] wd,
                        input int hold, input bit keep_req);
    logic [31:0] e_rd;
    logic        e_er;
    int          lat;
    ref_access(wr, sz, sg, ad, wd, e_rd, e_er);
    exp_q.push_back(e_rd);

    @(negedge clk);
    check({tag, " req_ready idle"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = ad; req_wdata = wd;
    @(posedge clk);
    #1;
    // Scramble inputs after the accepting edge; the captured copy must win.
    req_valid = 1'b0; req_write = ~wr; req_size = 2'($urandom_range(0, 3));
    req_signed = ~sg; req_addr = $urandom; req_wdata = $urandom;

    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (resp_valid) break;
      check({tag, " req_ready wait"}, {31'd0, req_ready}, 32'd0);
    end
    check({tag, " latency"}, 32'(lat), 32'(WAITC));
    check({tag, " rdata"}, resp_rdata, exp_q.pop_front());
    check({tag, " err"}, {31'd0, resp_err}, {31'd0, e_er});

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (keep_req) begin
        req_valid = 1'b1; req_addr = $urandom; req_size = 2'b10;
      end
      @(posedge clk);
      #1;
      check({tag, " hold valid"}, {31'd0, resp_valid}, 32'd1);
      check({tag, " hold rdata"}, resp_rdata, e_rd);
      check({tag, " hold err"}, {31'd0, resp_err}, {31'd0, e_er});
      check({tag, " hold ready"}, {31'd0, req_ready}, 32'd0);
    end

    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check({tag, " post valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, " post rdata"}, resp_rdata, 32'd0);
    check({tag, " post err"}, {31'd0, resp_err}, 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, " resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, " resp_rdata"}, resp_rdata, 32'd0);
    check({tag, " resp_err"}, {31'd0, resp_err}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ad;
    logic [1:0]  sz;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Word store/load, sub-word lanes, sign extension.
    do_req("sw10",    1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 0, 1'b0);
    do_req("lw10",    1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 1'b0);
    do_req("sb11",    1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FFAA, 0, 1'b0);
    do_req("lbu11",   1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 0, 1'b0);
    do_req("lb11",    1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 0, 1'b0);
    do_req("lw10b",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 1'b0);
    do_req("lh12",    1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0, 1'b0);
    do_req("sh12",    1'b1, 2'b01, 1'b0, 32'h12, 32'h1234_8001, 0, 1'b0);
    do_req("lh12b",   1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0, 1'b0);

    // Error cases leave memory unchanged.
    do_req("lw13",    1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 0, 1'b0);
    do_req("lh11",    1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 0, 1'b0);
    do_req("lw_oor",  1'b0, 2'b10, 1'b0, 32'(DEPTH * 4), 32'h0, 0, 1'b0);
    do_req("sw_oor",  1'b1, 2'b10, 1'b0, 32'(DEPTH * 4), 32'hCAFE_F00D, 0, 1'b0);
    do_req("sz11",    1'b1, 2'b11, 1'b0, 32'h10, 32'h5555_5555, 0, 1'b0);
    do_req("sw13err", 1'b1, 2'b10, 1'b0, 32'h13, 32'h6666_6666, 0, 1'b0);
    do_req("lw10c",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 1'b0);

    // Response back-pressure with a request held pending.
    do_req("hold",    1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5, 1'b1);
    do_req("afthold", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0, 1'b0);

    // Reset during WAIT aborts a store.
    do_req("sw20",    1'b1, 2'b10, 1'b0, 32'h20, 32'h0102_0304, 0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("abort in wait", {30'd0, dbg_state}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("abort reset");
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("abort reset hold");
    @(negedge clk);
    rst_n = 1'b1;
    do_req("lw20",    1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0, 1'b0);

    // Random phase: initialise a 16-word window, then mixed traffic.
    for (int w = 0; w < 16; w++)
      do_req("init", 1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom, 0, 1'b0);
    for (int k = 0; k < 80; k++) begin
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       ad = 32'(DEPTH * 4) + 32'($urandom_range(0, 64));
        1:       ad = $urandom;
        default: ad = 32'($urandom_range(0, 63));
      endcase
      do_req("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             ad, $urandom, $urandom_range(0, 3), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
